// File: rtl/tx_phy_pkg.sv
// Shared TX PHY definitions: symbol-select codes for the TX multiplexer and
// the framing sequencer state encoding.
package tx_phy_pkg;

  localparam logic [3:0] DK_DATA = 4'd0;
  localparam logic [3:0] DK_COM  = 4'd1;
  localparam logic [3:0] DK_SKP  = 4'd2;
  localparam logic [3:0] DK_STP  = 4'd3;
  localparam logic [3:0] DK_SDP  = 4'd4;
  localparam logic [3:0] DK_END  = 4'd5;
  localparam logic [3:0] DK_EDB  = 4'd6;
  localparam logic [3:0] DK_FTS  = 4'd7;
  localparam logic [3:0] DK_IDLE = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_FIN,
    ST_DISCARD,
    ST_SKP_COM,
    ST_SKP_SYM,
    ST_FTS_COM,
    ST_FTS_SYM
  } seq_state_e;

endpackage

// File: rtl/tx_skp_timer.sv
// SKP interval timer: raises a single pending request every INTERVAL enabled
// cycles and holds it (counter saturated) until the sequencer clears it.
module tx_skp_timer #(
  parameter int INTERVAL = 1180,
  parameter int CNT_W    = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic enb,
  input  logic clr,
  output logic skp_pending
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    if (enb) begin
      if (clr) pending_d = 1'b0;
      if (cnt_q == CNT_MAX) begin
        // A new expiry re-arms the request even if it is being cleared now.
        if (!(pending_q && !clr)) begin
          cnt_d     = '0;
          pending_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign skp_pending = pending_q;

endmodule

// File: rtl/tx_frame_seq.sv
// TX framing sequencer: frames data-layer packets with STP/SDP..END/EDB and
// inserts SKP/FTS ordered sets at packet boundaries. Outputs are Moore-decoded.
module tx_frame_seq
  import tx_phy_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3,
  parameter int CNT_W        = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       pkt_valid,
  input  logic       pkt_sop,
  input  logic       pkt_eop,
  input  logic       pkt_type,
  input  logic       pkt_abort,
  input  logic       fts_req,
  input  logic [7:0] fts_num,
  output logic       pkt_ready,
  output logic [3:0] control_dk,
  output logic       seq_busy,
  output logic       underrun_err
);

  // Handshake: a byte moves when pkt_valid && pkt_ready at a rising edge;
  // pkt_ready depends only on the state register and enb.
  localparam logic [7:0] SKP_LEN_C = 8'(SKP_LEN);

  seq_state_e state_q, state_d, bnd_st;
  logic       ptype_q, ptype_d;
  logic       abort_q, abort_d;
  logic       discard_q, discard_d;
  logic       underrun_q, underrun_d;
  logic       fts_pending_q, fts_pending_d;
  logic [7:0] fts_num_q, fts_num_d;
  logic [7:0] cnt_q, cnt_d;
  logic       skp_pending, skp_clr;

  tx_skp_timer #(
    .INTERVAL(SKP_INTERVAL),
    .CNT_W   (CNT_W)
  ) u_skp_timer (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .clr        (skp_clr),
    .skp_pending(skp_pending)
  );

  always_comb begin
    if (skp_pending)                 bnd_st = ST_SKP_COM;
    else if (fts_pending_q)          bnd_st = ST_FTS_COM;
    else if (pkt_valid && pkt_sop)   bnd_st = ST_START;
    else                             bnd_st = ST_IDLE;
  end

  always_comb begin
    state_d       = state_q;
    ptype_d       = ptype_q;
    abort_d       = abort_q;
    discard_d     = discard_q;
    underrun_d    = underrun_q;
    fts_pending_d = fts_pending_q;
    fts_num_d     = fts_num_q;
    cnt_d         = cnt_q;
    skp_clr       = 1'b0;
    if (enb) begin
      case (state_q)
        ST_IDLE:  state_d = bnd_st;
        ST_START: state_d = ST_DATA;
        ST_DATA: begin
          if (!pkt_valid) begin
            state_d    = ST_FIN;
            abort_d    = 1'b1;
            discard_d  = 1'b1;
            underrun_d = 1'b1;
          end else if (pkt_eop) begin
            state_d   = ST_FIN;
            abort_d   = pkt_abort;
            discard_d = 1'b0;
          end
        end
        ST_FIN:   state_d = discard_q ? ST_DISCARD : bnd_st;
        ST_DISCARD: begin
          // The byte on the bus is the dropped eop, so it cannot open a packet.
          if (pkt_valid && pkt_eop) state_d = (bnd_st == ST_START) ? ST_IDLE : bnd_st;
        end
        ST_SKP_COM: state_d = ST_SKP_SYM;
        ST_SKP_SYM: begin
          if (cnt_q == 8'd1) state_d = bnd_st;
          else               cnt_d   = cnt_q - 8'd1;
        end
        ST_FTS_COM: state_d = (cnt_q == 8'd0) ? bnd_st : ST_FTS_SYM;
        ST_FTS_SYM: begin
          if (cnt_q == 8'd1) state_d = bnd_st;
          else               cnt_d   = cnt_q - 8'd1;
        end
        default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_START) ptype_d = pkt_type;
      if (state_d == ST_SKP_COM) begin
        cnt_d   = SKP_LEN_C;
        skp_clr = 1'b1;
      end
      if (state_d == ST_FTS_COM) begin
        cnt_d         = fts_num_q;
        fts_pending_d = 1'b0;
      end
      if (fts_req) begin
        fts_pending_d = 1'b1;
        fts_num_d     = fts_num;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptype_q       <= 1'b0;
      abort_q       <= 1'b0;
      discard_q     <= 1'b0;
      underrun_q    <= 1'b0;
      fts_pending_q <= 1'b0;
      fts_num_q     <= 8'd0;
      cnt_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      ptype_q       <= ptype_d;
      abort_q       <= abort_d;
      discard_q     <= discard_d;
      underrun_q    <= underrun_d;
      fts_pending_q <= fts_pending_d;
      fts_num_q     <= fts_num_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    control_dk = DK_IDLE;
    pkt_ready  = 1'b0;
    case (state_q)
      ST_IDLE:    control_dk = DK_IDLE;
      ST_START:   control_dk = ptype_q ? DK_SDP : DK_STP;
      ST_DATA: begin
        control_dk = DK_DATA;
        pkt_ready  = enb;
      end
      ST_FIN:     control_dk = abort_q ? DK_EDB : DK_END;
      ST_DISCARD: begin
        control_dk = DK_IDLE;
        pkt_ready  = enb;
      end
      ST_SKP_COM: control_dk = DK_COM;
      ST_SKP_SYM: control_dk = DK_SKP;
      ST_FTS_COM: control_dk = DK_COM;
      ST_FTS_SYM: control_dk = DK_FTS;
      default:    control_dk = DK_IDLE;
    endcase
  end

  assign seq_busy     = (state_q != ST_IDLE);
  assign underrun_err = underrun_q;

endmodule

// File: tb/tb_tx_frame_seq.sv
// Directed bench for tx_frame_seq with a short SKP interval; each scenario
// task logs control_dk per cycle and compares it with a hand-derived sequence.
module tb_tx_frame_seq;

  logic       clk;
  logic       rst;
  logic       enb;
  logic       pkt_valid;
  logic       pkt_sop;
  logic       pkt_eop;
  logic       pkt_type;
  logic       pkt_abort;
  logic       fts_req;
  logic [7:0] fts_num;
  logic       pkt_ready;
  logic [3:0] control_dk;
  logic       seq_busy;
  logic       underrun_err;

  int checks = 0;
  int errors = 0;
  int rdy_cnt;
  logic [3:0] dk_log[$];
  logic       busy_log[$];
  logic [3:0] exp_q[$];

  tx_frame_seq #(
    .SKP_INTERVAL(16),
    .SKP_LEN     (3),
    .CNT_W       (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .pkt_valid   (pkt_valid),
    .pkt_sop     (pkt_sop),
    .pkt_eop     (pkt_eop),
    .pkt_type    (pkt_type),
    .pkt_abort   (pkt_abort),
    .fts_req     (fts_req),
    .fts_num     (fts_num),
    .pkt_ready   (pkt_ready),
    .control_dk  (control_dk),
    .seq_busy    (seq_busy),
    .underrun_err(underrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enb = 1'b1; pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
    pkt_type = 1'b0; pkt_abort = 1'b0; fts_req = 1'b0; fts_num = 8'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dk_log.delete();
    busy_log.delete();
    exp_q.delete();
    rdy_cnt = 0;
  endtask

  // One cycle: drive inputs on the falling edge, then log the Moore outputs.
  task automatic step(input logic v, input logic s, input logic e, input logic t,
                      input logic a, input logic f, input logic [7:0] fn, input logic en,
                      output logic rdy);
    @(negedge clk);
    pkt_valid = v; pkt_sop = s; pkt_eop = e; pkt_type = t;
    pkt_abort = a; fts_req = f; fts_num = fn; enb = en;
    #1;
    dk_log.push_back(control_dk);
    busy_log.push_back(seq_busy);
    rdy = pkt_ready;
    if (pkt_ready) rdy_cnt++;
  endtask

  task automatic idle_steps(input int n);
    logic rdy;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, rdy);
  endtask

  // Reactive source: holds each byte until it is accepted. Optional one-cycle
  // valid drop, two-cycle enb stall and an fts_req pulse at given byte indices.
  task automatic send_pkt(input int len, input logic typ, input logic abort,
                          input int drop_idx, input int stall_idx,
                          input int fts_idx, input logic [7:0] fts_n);
    int   idx = 0;
    int   budget = 0;
    int   stall = 0;
    bit   dropped = 0;
    bit   fts_done = 0;
    logic v, en, f, rdy;
    while (idx < len && budget < 200) begin
      v = 1'b1; en = 1'b1; f = 1'b0;
      if (idx == drop_idx && !dropped) begin v = 1'b0; dropped = 1; end
      if (idx == stall_idx && stall < 2) begin en = 1'b0; stall++; end
      if (idx == fts_idx && !fts_done) begin f = 1'b1; fts_done = 1; end
      step(v, idx == 0, idx == len - 1, typ, abort && (idx == len - 1), f, fts_n, en, rdy);
      if (rdy && v && en) idx++;
      budget++;
    end
    checks++;
    if (budget >= 200) begin
      errors++;
      $display("FAIL pkt_timeout: only %0d of %0d bytes accepted", idx, len);
    end
  endtask

  task automatic test_reset();
    logic rdy;
    do_reset();
    @(negedge clk);
    #1;
    checks++;
    if (control_dk !== 4'd8 || pkt_ready !== 1'b0 || seq_busy !== 1'b0 || underrun_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: dk=%0d rdy=%b busy=%b uerr=%b, need dk=8 rdy=0 busy=0 uerr=0",
               control_dk, pkt_ready, seq_busy, underrun_err);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, rdy);
      checks++;
      if (control_dk !== 4'd8 || rdy !== 1'b0 || seq_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: dk=%0d rdy=%b busy=%b, need 8/0/0", i, control_dk, rdy, seq_busy);
      end
    end
  endtask

  task automatic test_idle_nosop();
    logic rdy;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, rdy);
      checks++;
      if (control_dk !== 4'd8 || rdy !== 1'b0) begin
        errors++;
        $display("FAIL nosop[%0d]: dk=%0d rdy=%b, need dk=8 rdy=0", i, control_dk, rdy);
      end
    end
  endtask

  task automatic test_tlp();
    do_reset();
    send_pkt(4, 1'b0, 1'b0, -1, -1, -1, 8'd0);
    idle_steps(2);
    exp_q = '{4'd8, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd8};
    checks++;
    if (dk_log.size() != exp_q.size()) begin
      errors++;
      $display("FAIL tlp_len: %0d symbols, need %0d", dk_log.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (dk_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL tlp_dk[%0d]: got %0d, need %0d", i, dk_log[i], exp_q[i]);
      end
    end
    checks++;
    if (rdy_cnt != 4) begin
      errors++;
      $display("FAIL tlp_ready_cycles: got %0d, need 4", rdy_cnt);
    end
    checks++;
    if (busy_log[6] !== 1'b1 || busy_log[7] !== 1'b0) begin
      errors++;
      $display("FAIL tlp_busy: fin=%b idle=%b, need 1/0", busy_log[6], busy_log[7]);
    end
  endtask

  task automatic test_dllp();
    do_reset();
    send_pkt(4, 1'b1, 1'b0, -1, -1, -1, 8'd0);
    idle_steps(2);
    exp_q = '{4'd8, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd8};
    checks++;
    if (dk_log.size() != exp_q.size()) begin
      errors++;
      $display("FAIL dllp_len: %0d symbols, need %0d", dk_log.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (dk_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL dllp_dk[%0d]: got %0d, need %0d", i, dk_log[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    send_pkt(4, 1'b0, 1'b1, -1, -1, -1, 8'd0);
    idle_steps(2);
    exp_q = '{4'd8, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd6, 4'd8};
    checks++;
    if (dk_log.size() != exp_q.size()) begin
      errors++;
      $display("FAIL abort_len: %0d symbols, need %0d", dk_log.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (dk_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_dk[%0d]: got %0d, need %0d", i, dk_log[i], exp_q[i]);
      end
    end
    checks++;
    if (underrun_err !== 1'b0) begin
      errors++;
      $display("FAIL abort_uerr: got %b, need 0", underrun_err);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    send_pkt(5, 1'b0, 1'b0, 2, -1, -1, 8'd0);
    idle_steps(2);
    // The cycle with valid low still shows data; EDB follows, then DISCARD.
    exp_q = '{4'd8, 4'd3, 4'd0, 4'd0, 4'd0, 4'd6, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
    checks++;
    if (dk_log.size() != exp_q.size()) begin
      errors++;
      $display("FAIL underrun_len: %0d symbols, need %0d", dk_log.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (dk_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL underrun_dk[%0d]: got %0d, need %0d", i, dk_log[i], exp_q[i]);
      end
    end
    checks++;
    if (underrun_err !== 1'b1 || rdy_cnt != 6) begin
      errors++;
      $display("FAIL underrun_flags: uerr=%b ready_cycles=%0d, need 1 and 6", underrun_err, rdy_cnt);
    end
    checks++;
    if (busy_log.size() == 11 && (busy_log[6] !== 1'b1 || busy_log[9] !== 1'b0)) begin
      errors++;
      $display("FAIL underrun_busy: discard=%b idle=%b, need 1/0", busy_log[6], busy_log[9]);
    end
  endtask

  task automatic test_rst_mid();
    logic rdy;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, rdy);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, rdy);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, rdy);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, rdy);
    checks++;
    if (control_dk !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_pre: dk=%0d, need 0 before reset", control_dk);
    end
    do_reset();
    @(negedge clk);
    #1;
    checks++;
    if (control_dk !== 4'd8 || pkt_ready !== 1'b0 || seq_busy !== 1'b0 || underrun_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_post: dk=%0d rdy=%b busy=%b uerr=%b, need 8/0/0/0",
               control_dk, pkt_ready, seq_busy, underrun_err);
    end
    idle_steps(2);
    checks++;
    if (dk_log[0] !== 4'd8 || dk_log[1] !== 4'd8) begin
      errors++;
      $display("FAIL rstmid_noedb: dk=%0d,%0d, need 8,8", dk_log[0], dk_log[1]);
    end
  endtask

  task automatic test_enb_stall();
    do_reset();
    send_pkt(3, 1'b0, 1'b0, -1, 1, -1, 8'd0);
    idle_steps(1);
    exp_q = '{4'd8, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5};
    checks++;
    if (dk_log.size() != exp_q.size()) begin
      errors++;
      $display("FAIL enb_len: %0d symbols, need %0d", dk_log.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (dk_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL enb_dk[%0d]: got %0d, need %0d", i, dk_log[i], exp_q[i]);
      end
    end
    checks++;
    if (rdy_cnt != 3) begin
      errors++;
      $display("FAIL enb_ready_cycles: got %0d, need 3", rdy_cnt);
    end
  endtask

  task automatic test_skp();
    do_reset();
    send_pkt(20, 1'b0, 1'b0, -1, -1, -1, 8'd0);
    send_pkt(2, 1'b0, 1'b0, -1, -1, -1, 8'd0);
    idle_steps(1);
    exp_q = '{4'd8, 4'd3};
    repeat (20) exp_q.push_back(4'd0);
    exp_q = {exp_q, 4'd5, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd0, 4'd0, 4'd5};
    checks++;
    if (dk_log.size() != exp_q.size()) begin
      errors++;
      $display("FAIL skp_len: %0d symbols, need %0d", dk_log.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (dk_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL skp_dk[%0d]: got %0d, need %0d", i, dk_log[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fts_after_skp();
    do_reset();
    send_pkt(16, 1'b0, 1'b0, -1, -1, 3, 8'd4);
    send_pkt(1, 1'b1, 1'b0, -1, -1, -1, 8'd0);
    idle_steps(1);
    exp_q = '{4'd8, 4'd3};
    repeat (16) exp_q.push_back(4'd0);
    exp_q = {exp_q, 4'd5, 4'd1, 4'd2, 4'd2, 4'd2, 4'd1, 4'd7, 4'd7, 4'd7, 4'd7, 4'd4, 4'd0, 4'd5};
    checks++;
    if (dk_log.size() != exp_q.size()) begin
      errors++;
      $display("FAIL fts_len: %0d symbols, need %0d", dk_log.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (dk_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL fts_dk[%0d]: got %0d, need %0d", i, dk_log[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enb = 1'b1; pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
    pkt_type = 1'b0; pkt_abort = 1'b0; fts_req = 1'b0; fts_num = 8'd0;
    test_reset();
    test_idle_nosop();
    test_tlp();
    test_dllp();
    test_abort();
    test_underrun();
    test_rst_mid();
    test_enb_stall();
    test_skp();
    test_fts_after_skp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
